dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 16-bit byte-addressed data memory. It sits between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). It grants one request at a time and drives the memory's address, write-data and write-enable lines from latched request registers. It returns registered read data with a one-cycle acknowledge.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 36 +++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   ADDR_W / DATA_W : default byte-address and word widths
//   PORT_CPU/AUX    : port ids (load/store unit, secondary master)
//   state_e         : sequencer state encoding
package dmem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
//   req[1:0]   : in  - pending requests, bit index = port id
//   last_grant : in  - port granted most recently
//   winner     : out - port to grant (meaningful only when req != 0)
// Build option DMEM_ARB_RR_EN: defined -> round-robin on a tie,
// undefined -> port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

  always_comb begin
    // With no request the choice is irrelevant; holding the last grant keeps
    // the output quiet.
    winner = last_grant;
`ifdef DMEM_ARB_RR_EN
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else if (req[PORT_CPU]) begin
      winner = PORT_CPU;
    end else if (req[PORT_AUX]) begin
      winner = PORT_AUX;
    end
`else
    if (req[PORT_CPU]) begin
      winner = PORT_CPU;
    end else if (req[PORT_AUX]) begin
      winner = PORT_AUX;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 16-bit byte-addressed data memory.
// Port 0 is the CPU load/store unit, port 1 a secondary master (DMA/debug).
//   clk, rst_n               : clock, async active-low reset
//   pN_req/we/addr/wdata     : in  - request and qualifiers, held until ack
//   pN_ack                   : out - one-cycle completion pulse
//   pN_rdata                 : out - read data, held until the next ack on port N
//   mem_addr/mem_din/mem_en  : out - memory address, write data, write enable
//   mem_dout                 : in  - combinational memory read data
//   busy                     : out - high in ACCESS and DONE
//   grant_id                 : out - port currently or most recently granted
// Build option DMEM_ARB_RR_EN: round-robin tie break (else fixed, port 0 first).
//
// state  | meaning
// IDLE   | waiting; samples requests and latches the winner's qualifiers
// ACCESS | memory driven from latched request; read data captured at end
// DONE   | winner's ack high; requests ignored
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              grant_id
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              grant_q, grant_d;

  logic [1:0] req;
  logic       pick_win;
  logic       pick_last;

  assign req = {p1_req, p0_req};

`ifdef DMEM_ARB_RR_EN
  // Separate from grant_id: it resets to "port 1 served last" so that port 0
  // is preferred on the first tie, while grant_id itself resets to 0.
  logic rr_last_q, rr_last_d;
  assign pick_last = rr_last_q;
`else
  assign pick_last = grant_q;
`endif

  dmem_arb_pick u_pick (
    .req        (req),
    .last_grant (pick_last),
    .winner     (pick_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      grant_q  <= PORT_CPU;
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= PORT_AUX;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      grant_q  <= grant_d;
`ifdef DMEM_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant_d  = grant_q;
`ifdef DMEM_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          win_d   = pick_win;
          grant_d = pick_win;
          we_d    = pick_win ? p1_we    : p0_we;
          addr_d  = pick_win ? p1_addr  : p0_addr;
          wdata_d = pick_win ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_RR_EN
          rr_last_d = pick_win;
`endif
        end
      end
      ACCESS: begin
        state_d       = DONE;
        ack_d[win_q]  = 1'b1;
        if (!we_q) begin
          if (win_q == PORT_AUX) begin
            rdata1_d = mem_dout;
          end else begin
            rdata0_d = mem_dout;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (state_q == ACCESS) begin
      mem_en   = we_q;
      mem_addr = addr_q;
      mem_din  = wdata_q;
    end
    p0_ack   = ack_q[PORT_CPU];
    p1_ack   = ack_q[PORT_AUX];
    p0_rdata = rdata0_q;
    p1_rdata = rdata1_q;
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, mem_en, busy, grant_id;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_din, mem_dout, mem_addr_p1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_dout(mem_dout),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory emulation: big-endian word over a byte array, second byte wraps.
  logic [7:0] emem [0:65535];
  assign mem_addr_p1 = mem_addr + 16'd1;
  assign mem_dout    = {emem[mem_addr], emem[mem_addr_p1]};
  always @(posedge clk) begin
    if (mem_en) begin
      emem[mem_addr]    <= mem_din[15:8];
      emem[mem_addr_p1] <= mem_din[7:0];
    end
  end

  // Reference model: transaction-level memory, per-port read registers, tie preference.
  logic [7:0]  rmem [0:65535];
  logic [15:0] ref_rd [2];
`ifdef DMEM_ARB_RR_EN
  int pref;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int tie_winner();
`ifdef DMEM_ARB_RR_EN
    return pref;
`else
    return 0;
`endif
  endfunction

  task automatic model_txn(input int port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    if (we) begin
      rmem[addr] = wdata[15:8];
      rmem[a1]   = wdata[7:0];
    end else begin
      ref_rd[port] = {rmem[addr], rmem[a1]};
    end
`ifdef DMEM_ARB_RR_EN
    pref = 1 - port;
`endif
  endtask

  task automatic model_reset();
    ref_rd[0] = '0;
    ref_rd[1] = '0;
`ifdef DMEM_ARB_RR_EN
    pref = 0;
`endif
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // Issue requests, drop each req when its ack is seen, record what happened.
  task automatic drive(input logic r0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic we1, input logic [15:0] a1, input logic [15:0] d1,
                       output int first, output int lat0, output int lat1, output int en_cnt,
                       output logic [15:0] en_a, output logic [15:0] en_d,
                       output logic [15:0] rd0, output logic [15:0] rd1);
    logic pend0, pend1;
    int   spurious;
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    first = -1; lat0 = 0; lat1 = 0; en_cnt = 0; en_a = '0; en_d = '0; rd0 = '0; rd1 = '0;
    pend0 = r0; pend1 = r1; spurious = 0;
    for (int c = 1; c <= 12 && (pend0 || pend1); c++) begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        en_cnt++;
        en_a = mem_addr;
        en_d = mem_din;
      end
      if (p0_ack) begin
        if (pend0) begin
          lat0 = c; rd0 = p0_rdata; pend0 = 1'b0; p0_req = 1'b0;
          if (first < 0) first = 0;
        end else spurious++;
      end
      if (p1_ack) begin
        if (pend1) begin
          lat1 = c; rd1 = p1_rdata; pend1 = 1'b0; p1_req = 1'b0;
          if (first < 0) first = 1;
        end else spurious++;
      end
    end
    chk("ack_timeout", {30'd0, pend1, pend0}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_after", {29'd0, busy, p1_ack, p0_ack}, 32'd0);
    chk("spurious_ack", spurious, 0);
  endtask

  // One round checked against the model; works for single or simultaneous requests.
  task automatic run_round(input logic r0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
                           input logic r1, input logic we1, input logic [15:0] a1, input logic [15:0] d1);
    int first, lat0, lat1, en_cnt, win, exp_lat0, exp_lat1;
    logic [15:0] en_a, en_d, rd0, rd1;
    win = (r0 && r1) ? tie_winner() : (r1 ? 1 : 0);
    exp_lat0 = 0; exp_lat1 = 0;
    if (win == 0) model_txn(0, we0, a0, d0); else model_txn(1, we1, a1, d1);
    if (r0 && r1) begin
      if (win == 0) model_txn(1, we1, a1, d1); else model_txn(0, we0, a0, d0);
      exp_lat0 = (win == 0) ? 2 : 5;
      exp_lat1 = (win == 1) ? 2 : 5;
    end else begin
      if (r0) exp_lat0 = 2;
      if (r1) exp_lat1 = 2;
    end
    drive(r0, we0, a0, d0, r1, we1, a1, d1, first, lat0, lat1, en_cnt, en_a, en_d, rd0, rd1);
    chk("rr_first", first, win);
    chk("rr_lat0", lat0, exp_lat0);
    chk("rr_lat1", lat1, exp_lat1);
    chk("rr_en_cnt", en_cnt, (r0 & we0) + (r1 & we1));
    if (r0) chk("rr_rd0", rd0, ref_rd[0]);
    if (r1) chk("rr_rd1", rd1, ref_rd[1]);
    chk("rr_hold0", p0_rdata, ref_rd[0]);
    chk("rr_hold1", p1_rdata, ref_rd[1]);
    chk("rr_grant", grant_id, (r0 && r1) ? 1 - win : win);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [15:0] exp_other;
  } vec_t;

  vec_t vt[7];

  initial begin
    int first, lat0, lat1, en_cnt, lat_a, lat_b, nack;
    logic [15:0] en_a, en_d, rd0, rd1, rd_b;

    vt[0] = '{0, 1'b1, 16'h0010, 16'hABCD, 16'h0000, 16'h0000};
    vt[1] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 16'h0000};
    vt[2] = '{0, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 16'hABCD};
    vt[3] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD};
    vt[4] = '{1, 1'b0, 16'h0000, 16'h0000, 16'h3400, 16'h1234};
    vt[5] = '{1, 1'b1, 16'h0001, 16'hBEEF, 16'h3400, 16'h1234};
    vt[6] = '{0, 1'b0, 16'h0000, 16'h0000, 16'h34BE, 16'h3400};

    for (int i = 0; i < 65536; i++) begin
      emem[i] = 8'h00;
      rmem[i] = 8'h00;
    end
    model_reset();

    #3;
    chk("in_reset_en", mem_en, 0);
    chk("in_reset_busy", busy, 0);
    apply_reset();
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p1_ack", p1_ack, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);

    // Directed single-port table: write, readback, wrap at 0xFFFF.
    for (int i = 0; i < 7; i++) begin
      if (vt[i].port == 0)
        drive(1'b1, vt[i].we, vt[i].addr, vt[i].wdata, 1'b0, 1'b0, 16'h0, 16'h0,
              first, lat0, lat1, en_cnt, en_a, en_d, rd0, rd1);
      else
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata,
              first, lat0, lat1, en_cnt, en_a, en_d, rd0, rd1);
      model_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata);
      chk("vec_lat", (vt[i].port == 0) ? lat0 : lat1, 2);
      chk("vec_rdata", (vt[i].port == 0) ? rd0 : rd1, vt[i].exp_rd);
      chk("vec_other_rdata", (vt[i].port == 0) ? p1_rdata : p0_rdata, vt[i].exp_other);
      chk("vec_en_cnt", en_cnt, vt[i].we);
      if (vt[i].we) begin
        chk("vec_mem_addr", en_a, vt[i].addr);
        chk("vec_mem_din", en_d, vt[i].wdata);
      end
      chk("vec_grant", grant_id, vt[i].port);
    end

    // Simultaneous requests from reset, then repeated ties.
    apply_reset();
    run_round(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
    run_round(1'b1, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
    run_round(1'b1, 1'b1, 16'h0040, 16'h1111, 1'b1, 1'b1, 16'h0040, 16'h2222);
    run_round(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);

    // p0 keeps req through the cycle after ack: a second access follows.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    lat_a = 0; lat_b = 0; nack = 0; rd_b = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (p0_ack) begin
        nack++;
        if (nack == 1) lat_a = c;
        else begin lat_b = c; rd_b = p0_rdata; end
      end
      if (c == 4) p0_req = 1'b0;
    end
    model_txn(0, 1'b0, 16'h0010, 16'h0);
    model_txn(0, 1'b0, 16'h0010, 16'h0);
    chk("hold_ack_count", nack, 2);
    chk("hold_first_lat", lat_a, 2);
    chk("hold_second_lat", lat_b, 5);
    chk("hold_rdata", rd_b, ref_rd[0]);

    // p1 arrives while p0 is in ACCESS: served right after DONE.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    lat_a = 0; lat_b = 0; rd_b = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'hFFFF;
      end
      if (p0_ack) begin lat_a = c; p0_req = 1'b0; end
      if (p1_ack) begin lat_b = c; rd_b = p1_rdata; p1_req = 1'b0; end
    end
    model_txn(0, 1'b0, 16'h0010, 16'h0);
    model_txn(1, 1'b0, 16'hFFFF, 16'h0);
    chk("busy_p0_lat", lat_a, 2);
    chk("busy_p1_lat", lat_b, 5);
    chk("busy_p1_rdata", rd_b, ref_rd[1]);

    // Reset asserted mid-ACCESS: no commit, no ack, mem_en drops at once.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 16'h5555;
    @(posedge clk);
    #1;
    chk("rst_mid_pre_en", mem_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en_async", mem_en, 0);
    chk("rst_mid_busy", busy, 0);
    p1_req = 1'b0;
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack) nack++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (p0_ack || p1_ack || busy) nack++;
    end
    chk("rst_mid_no_ack", nack, 0);
    run_round(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_mid_no_commit", (ref_rd[0] == 16'h5555), 0);

    // Randomised rounds against the model; addresses cluster around the wrap.
    for (int n = 0; n < 80; n++) begin
      int mask;
      mask = $urandom_range(1, 3);
      run_round(mask[0], 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)) - 16'd4,
                16'($urandom),
                mask[1], 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)) - 16'd4,
                16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
